// File: rtl/multicycle_control_unit_if.sv
// Control/handshake bundle between the multicycle control unit and its datapath.
// The control unit is the master: it reads opcode/flags and drives every control line.
interface multicycle_control_unit_if;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        imem_read;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        reg2loc;
  logic        alusrc;
  logic        memtoreg;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic [1:0]  aluop;

  modport master (
    input  opcode, zero, mem_ready,
    output imem_read, ir_write, pc_write, pc_src, reg2loc, alusrc,
           memtoreg, regwrite, memread, memwrite, aluop
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  imem_read, ir_write, pc_write, pc_src, reg2loc, alusrc,
           memtoreg, regwrite, memread, memwrite, aluop
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP for
// undecodable opcodes and a retired-instruction counter.
module multicycle_control_unit #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus,
  output logic [2:0]                state,
  output logic                      illegal_op,
  output logic [CNT_W-1:0]          retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ILL  = 3'd0,
    C_B    = 3'd1,
    C_CBZ  = 3'd2,
    C_LDUR = 3'd3,
    C_STUR = 3'd4,
    C_R    = 3'd5
  } cls_t;

  // Ordered casez: the first matching pattern decides the class.
  function automatic cls_t decode_op(input logic [10:0] op);
    casez (op)
      11'b000101?????: decode_op = C_B;
      11'b10110100???: decode_op = C_CBZ;
      11'b11111000010: decode_op = C_LDUR;
      11'b11111000000: decode_op = C_STUR;
      11'b1??0101?000: decode_op = C_R;
      default:         decode_op = C_ILL;
    endcase
  endfunction

  state_t state_q, state_d;
  cls_t   cls_q;
  cls_t   op_cls;
  logic   ready;
  logic   retire;
  logic   imem_read_c, ir_write_c, pc_write_c;

  assign op_cls = decode_op(bus.opcode);
  assign ready  = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    imem_read_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    bus.pc_src   = 1'b0;
    bus.reg2loc  = 1'b0;
    bus.alusrc   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.aluop    = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_read_c = 1'b1;
        if (ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: state_d = (op_cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            bus.aluop = 2'b10;
            state_d   = S_WB;
          end
          C_LDUR: begin
            bus.alusrc = 1'b1;
            state_d    = S_MEM;
          end
          C_STUR: begin
            bus.alusrc  = 1'b1;
            bus.reg2loc = 1'b1;
            state_d     = S_MEM;
          end
          C_CBZ: begin
            bus.aluop   = 2'b01;
            bus.reg2loc = 1'b1;
            pc_write_c  = bus.zero;
            bus.pc_src  = bus.zero;
            state_d     = S_FETCH;
            retire      = 1'b1;
          end
          C_B: begin
            pc_write_c = 1'b1;
            bus.pc_src = 1'b1;
            state_d    = S_FETCH;
            retire     = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        bus.memread  = (cls_q == C_LDUR);
        bus.memwrite = (cls_q == C_STUR);
        if (ready) begin
          if (cls_q == C_LDUR) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = (cls_q == C_LDUR);
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset parks the FSM in FETCH, so the FETCH-only requests are masked while rst_n is low.
  assign bus.imem_read = imem_read_c & rst_n;
  assign bus.ir_write  = ir_write_c  & rst_n;
  assign bus.pc_write  = pc_write_c  & rst_n;
  assign state         = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      cls_q      <= C_ILL;
      illegal_op <= 1'b0;
      retired    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= op_cls;
      if (state_d == S_TRAP) illegal_op <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1: 1 = stall FETCH/MEM until mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 Parameter CNT_W, default 16: width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 opcode  input  11  instruction[31:21] from instruction register; valid from DECODE onward.
REQ-006 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-007 mem_ready  input  1  memory handshake; access completes on a cycle with request and mem_ready both high.
REQ-008 imem_read  output  1  instruction fetch request.
REQ-009 ir_write, pc_write  output  1 each  load IR; load PC.
REQ-010 pc_src  output  1  0 = PC+4, 1 = branch target.
REQ-011 reg2loc, alusrc, memtoreg, regwrite, memread, memwrite  output  1 each  datapath controls, LEGv8 meaning.
REQ-012 aluop  output  2  00 add, 01 pass-B/zero test, 10 funct decode.
REQ-013 state  output  3  current FSM state code.
REQ-014 illegal_op  output  1  sticky undecodable-opcode flag.
REQ-015 retired  output  CNT_W  count of completed instructions.

Function
REQ-016 States/codes: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5; codes 6-7 SHALL recover to FETCH on the next edge.
REQ-017 Opcode classes, first match wins: B 000101xxxxx; CBZ 10110100xxx; LDUR 11111000010; STUR 11111000000; R-type 1xx0101x000; anything else illegal.
REQ-018 Class latched into an internal register in DECODE; opcode changes after DECODE SHALL NOT affect the current instruction.
REQ-019 Outputs SHALL be Moore functions of state and latched class; every output not asserted SHALL be 0 (never X).
REQ-020 FETCH: imem_read=1; on handshake, ir_write=1, pc_write=1, pc_src=0, go to DECODE; otherwise stay in FETCH.
REQ-021 DECODE: no outputs asserted; illegal -> TRAP, else -> EXEC.
REQ-022 EXEC R-type: aluop=10, alusrc=0, reg2loc=0 -> WB.
REQ-023 EXEC LDUR/STUR: aluop=00, alusrc=1, reg2loc=1 for STUR only -> MEM.
REQ-024 EXEC CBZ: aluop=01, reg2loc=1; zero=1 -> pc_write=1, pc_src=1; -> FETCH.
REQ-025 EXEC B: pc_write=1, pc_src=1 unconditionally -> FETCH.
REQ-026 MEM: memread=1 for LDUR, memwrite=1 for STUR, held until handshake; then LDUR -> WB, STUR -> FETCH.
REQ-027 WB: regwrite=1; memtoreg=1 for LDUR, 0 for R-type -> FETCH.
REQ-028 TRAP: illegal_op=1, no other outputs, remain until reset.
REQ-029 retired SHALL increment by 1, modulo 2^CNT_W, on the final cycle of each instruction (transition into FETCH from EXEC, MEM or WB); all-ones wraps to 0.
REQ-030 Latency, no wait states: B and CBZ 3 cycles; R-type and STUR 4; LDUR 5; each mem_ready-low cycle in FETCH/MEM adds 1.
REQ-031 mem_ready high outside FETCH/MEM SHALL be ignored.

Reset
REQ-032 rst_n low SHALL immediately force state=FETCH, retired=0, illegal_op=0, class=illegal; every output except imem_read and state SHALL read 0, regardless of clock.
REQ-033 During reset, imem_read SHALL be 0.
REQ-034 Reset asserted mid-instruction (e.g. in MEM with memwrite high) SHALL drop the request within the same cycle; no partial completion and no retired increment.
REQ-035 First rising edge after rst_n deasserts SHALL begin FETCH with imem_read=1.

Verification
REQ-036 ADD 10001011000, mem_ready=1: states 0,1,2,4,0; regwrite=1 only in WB; aluop=10 in EXEC; retired 0->1.
REQ-037 LDUR 11111000010, mem_ready low 2 cycles in MEM: memread held 3 cycles; WB memtoreg=1; total 7 cycles.
REQ-038 CBZ 10110100101: zero=1 -> pc_write=1, pc_src=1 in EXEC; zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-039 Opcode 00000000000: DECODE -> TRAP; illegal_op=1 stays high 20 cycles; retired unchanged.
REQ-040 STUR with rst_n pulsed low during MEM: memwrite=0 same cycle, state=0, retired=0; MEM_WAIT_EN=0 build: STUR completes in 4 cycles with mem_ready tied 0; CNT_W=2: four retirements wrap retired to 0.
